// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Definitions shared by the EX/MEM register + MEM stage:
//   - register file widths (32-bit data, 5-bit register address)
//   - data-RAM access size encodings MEM_SIZE_B / MEM_SIZE_H / MEM_SIZE_W
//   - access FSM state encoding ST_IDLE / ST_ACCESS
//   - is_misaligned(): alignment rule shared by the FSM and the WB error flag
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_H = 2'b01;
   localparam logic [1:0] MEM_SIZE_W = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   // Bytes are always aligned; halves need an even address; words (and the
   // unused 2'b11 size, treated as a word) need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (size)
         MEM_SIZE_B: mis = 1'b0;
         MEM_SIZE_H: mis = addr_lo[0];
         MEM_SIZE_W: mis = (addr_lo != 2'b00);
         default:    mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane steering for the data RAM.
// Ports:
//   i_size       access size (MEM_SIZE_B/H/W)
//   i_signed     sign-extend loads when 1, zero-extend when 0
//   i_addr_lo    byte offset within the word (addr[1:0])
//   i_store_data register value to be stored
//   i_load_data  raw 32-bit word returned by the RAM
//   o_sel        byte enables for the store
//   o_wdata      store data replicated onto every lane it could occupy
//   o_load_ext   selected load lane, extended to 32 bits
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_data,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store side: byte enables plus replicated write data.
   always_comb begin
      o_sel   = 4'b0000;
      o_wdata = 32'd0;
      case (i_size)
         MEM_SIZE_B: begin
            o_sel   = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_store_data[7:0]}};
         end
         MEM_SIZE_H: begin
            if (i_addr_lo[1]) begin
               o_sel = 4'b1100;
            end else begin
               o_sel = 4'b0011;
            end
            o_wdata = {2{i_store_data[15:0]}};
         end
         default: begin
            o_sel   = 4'b1111;
            o_wdata = i_store_data;
         end
      endcase
   end

   // Load side: pick the addressed lane, then zero- or sign-extend it.
   always_comb begin
      w_byte     = 8'd0;
      w_half     = 16'd0;
      o_load_ext = 32'd0;
      case (i_addr_lo)
         2'b00:   w_byte = i_load_data[7:0];
         2'b01:   w_byte = i_load_data[15:8];
         2'b10:   w_byte = i_load_data[23:16];
         default: w_byte = i_load_data[31:24];
      endcase
      if (i_addr_lo[1]) begin
         w_half = i_load_data[31:16];
      end else begin
         w_half = i_load_data[15:0];
      end
      case (i_size)
         MEM_SIZE_B: o_load_ext = {{24{i_signed & w_byte[7]}}, w_byte};
         MEM_SIZE_H: o_load_ext = {{16{i_signed & w_half[15]}}, w_half};
         default:    o_load_ext = i_load_data;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// EX/MEM pipeline register merged with the MEM stage of the 5-stage MIPS
// pipeline. Latches EX results, performs byte/half/word loads and stores over
// a req/ack data-RAM handshake, stalls upstream while an access is pending and
// drives the MEM/WB outputs used by the register file and HI/LO register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   *_EX                     EX stage results and control (captured when not stalled)
//   ram_req/we/addr/wdata/sel  data-RAM request, stable for the whole access
//   ram_ack, ram_rdata       RAM completion strobe and read data
//   stall_req                hold IF, IF_ID, ID_EX and this stage's latch
//   *_WB                     registered MEM/WB outputs
//   addr_err_WB              one-cycle misaligned access flag
//   fwd_*_MEM                MEM-stage forwarding of non-memory results
//
// Build option: define MEM_FWD_EN to drive fwd_*_MEM from the latch;
// otherwise the forwarding ports are tied to zero.
// -----------------------------------------------------------------------------
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_EX,
   input  logic              WriteReg_EX,
   input  logic              MemOrAlu_EX,
   input  logic              WriteMem_EX,
   input  logic [1:0]        mem_size_EX,
   input  logic              mem_signed_EX,
   input  logic [ADDR_W-1:0] target_EX,
   input  logic [DATA_W-1:0] alu_out_EX,
   input  logic [DATA_W-1:0] rdata_2_EX,
   input  logic              we_hi_EX,
   input  logic              we_lo_EX,
   input  logic [DATA_W-1:0] hi_EX,
   input  logic [DATA_W-1:0] lo_EX,
   output logic              ram_req,
   output logic              ram_we,
   output logic [31:0]       ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_sel,
   input  logic              ram_ack,
   input  logic [31:0]       ram_rdata,
   output logic              stall_req,
   output logic              valid_WB,
   output logic              WriteReg_WB,
   output logic              we_hi_WB,
   output logic              we_lo_WB,
   output logic [ADDR_W-1:0] target_WB,
   output logic [DATA_W-1:0] wdata_WB,
   output logic [DATA_W-1:0] hi_WB,
   output logic [DATA_W-1:0] lo_WB,
   output logic              addr_err_WB,
   output logic              fwd_we_MEM,
   output logic [ADDR_W-1:0] fwd_addr_MEM,
   output logic [DATA_W-1:0] fwd_data_MEM
);

   // EX/MEM latch
   logic              r_valid;
   logic              r_write_reg;
   logic              r_mem_or_alu;
   logic              r_write_mem;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [ADDR_W-1:0] r_target;
   logic [DATA_W-1:0] r_alu_out;
   logic [DATA_W-1:0] r_store_data;
   logic              r_we_hi;
   logic              r_we_lo;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   // access FSM
   mem_state_e        r_state;
   logic              r_ram_req;

   // MEM/WB registers
   logic              r_valid_wb;
   logic              r_write_reg_wb;
   logic              r_we_hi_wb;
   logic              r_we_lo_wb;
   logic [ADDR_W-1:0] r_target_wb;
   logic [DATA_W-1:0] r_wdata_wb;
   logic [DATA_W-1:0] r_hi_wb;
   logic [DATA_W-1:0] r_lo_wb;
   logic              r_addr_err_wb;

   logic              w_in_access;
   logic              w_stall;
   logic              w_ex_access;
   logic              w_addr_err;
   logic              w_load_hit;
   logic [3:0]        w_sel;
   logic [31:0]       w_wdata;
   logic [31:0]       w_load_ext;

   assign w_in_access = (r_state == ST_ACCESS);
   // The ack cycle releases the stall so the next op is latched on the same
   // edge that completes the current access.
   assign w_stall     = w_in_access && !ram_ack;
   // An incoming op needs the RAM only if it is a real, aligned memory op;
   // misaligned ops flow through like ALU ops.
   assign w_ex_access = valid_EX && (MemOrAlu_EX || WriteMem_EX) &&
                        !is_misaligned(mem_size_EX, alu_out_EX[1:0]);
   assign w_addr_err  = r_valid && (r_mem_or_alu || r_write_mem) &&
                        is_misaligned(r_size, r_alu_out[1:0]);
   // Only a load completing its RAM access returns memory data.
   assign w_load_hit  = w_in_access && r_mem_or_alu;

   mem_lane_align u_lane_align (
      .i_size       (r_size),
      .i_signed     (r_signed),
      .i_addr_lo    (r_alu_out[1:0]),
      .i_store_data (r_store_data),
      .i_load_data  (ram_rdata),
      .o_sel        (w_sel),
      .o_wdata      (w_wdata),
      .o_load_ext   (w_load_ext)
   );

   // EX/MEM latch: capture EX results whenever the stage is not stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_write_reg  <= 1'b0;
         r_mem_or_alu <= 1'b0;
         r_write_mem  <= 1'b0;
         r_size       <= 2'b00;
         r_signed     <= 1'b0;
         r_target     <= {ADDR_W{1'b0}};
         r_alu_out    <= {DATA_W{1'b0}};
         r_store_data <= {DATA_W{1'b0}};
         r_we_hi      <= 1'b0;
         r_we_lo      <= 1'b0;
         r_hi         <= {DATA_W{1'b0}};
         r_lo         <= {DATA_W{1'b0}};
      end else if (!w_stall) begin
         r_valid      <= valid_EX;
         r_write_reg  <= WriteReg_EX;
         r_mem_or_alu <= MemOrAlu_EX;
         r_write_mem  <= WriteMem_EX;
         r_size       <= mem_size_EX;
         r_signed     <= mem_signed_EX;
         r_target     <= target_EX;
         r_alu_out    <= alu_out_EX;
         r_store_data <= rdata_2_EX;
         r_we_hi      <= we_hi_EX;
         r_we_lo      <= we_lo_EX;
         r_hi         <= hi_EX;
         r_lo         <= lo_EX;
      end
   end

   // Access FSM with registered RAM request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ram_req <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state   <= w_ex_access ? ST_ACCESS : ST_IDLE;
               r_ram_req <= w_ex_access;
            end
            ST_ACCESS: begin
               // on ack a back-to-back memory op re-enters ACCESS directly
               if (ram_ack) begin
                  r_state   <= w_ex_access ? ST_ACCESS : ST_IDLE;
                  r_ram_req <= w_ex_access;
               end else begin
                  r_state   <= ST_ACCESS;
                  r_ram_req <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_ram_req <= 1'b0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while waiting on the RAM, else retire the latch.
   always_ff @(posedge clk) begin
      if (rst || w_stall || !r_valid) begin
         r_valid_wb     <= 1'b0;
         r_write_reg_wb <= 1'b0;
         r_we_hi_wb     <= 1'b0;
         r_we_lo_wb     <= 1'b0;
         r_target_wb    <= {ADDR_W{1'b0}};
         r_wdata_wb     <= {DATA_W{1'b0}};
         r_hi_wb        <= {DATA_W{1'b0}};
         r_lo_wb        <= {DATA_W{1'b0}};
         r_addr_err_wb  <= 1'b0;
      end else begin
         r_valid_wb     <= 1'b1;
         r_write_reg_wb <= r_write_reg && !w_addr_err;
         r_we_hi_wb     <= r_we_hi;
         r_we_lo_wb     <= r_we_lo;
         r_target_wb    <= r_target;
         r_wdata_wb     <= w_load_hit ? w_load_ext : r_alu_out;
         r_hi_wb        <= r_hi;
         r_lo_wb        <= r_lo;
         r_addr_err_wb  <= w_addr_err;
      end
   end

   // RAM interface: everything is decoded from held registers, so it stays
   // stable for the whole access and reads as zero outside it.
   assign ram_req   = r_ram_req;
   assign stall_req = w_stall;
   assign ram_we    = w_in_access && r_write_mem;
   assign ram_addr  = w_in_access ? {r_alu_out[31:2], 2'b00} : 32'd0;
   assign ram_sel   = w_in_access ? w_sel : 4'b0000;
   assign ram_wdata = w_in_access ? w_wdata : 32'd0;

   assign valid_WB    = r_valid_wb;
   assign WriteReg_WB = r_write_reg_wb;
   assign we_hi_WB    = r_we_hi_wb;
   assign we_lo_WB    = r_we_lo_wb;
   assign target_WB   = r_target_wb;
   assign wdata_WB    = r_wdata_wb;
   assign hi_WB       = r_hi_wb;
   assign lo_WB       = r_lo_wb;
   assign addr_err_WB = r_addr_err_wb;

`ifdef MEM_FWD_EN
   // Loads have no data yet in MEM, so only non-memory results forward.
   assign fwd_we_MEM   = r_valid && r_write_reg && !r_mem_or_alu;
   assign fwd_addr_MEM = r_target;
   assign fwd_data_MEM = r_alu_out;
`else
   assign fwd_we_MEM   = 1'b0;
   assign fwd_addr_MEM = {ADDR_W{1'b0}};
   assign fwd_data_MEM = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model of the stage.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

   localparam int AW = 5;

   typedef struct packed {
      logic          valid;
      logic          wreg;
      logic          mor;
      logic          wmem;
      logic [1:0]    size;
      logic          sgn;
      logic [AW-1:0] tgt;
      logic [31:0]   alu;
      logic [31:0]   st;
      logic          whi;
      logic          wlo;
      logic [31:0]   hi;
      logic [31:0]   lo;
   } op_t;

   typedef struct packed {
      logic          valid;
      logic          wreg;
      logic          whi;
      logic          wlo;
      logic [AW-1:0] tgt;
      logic [31:0]   wdata;
      logic [31:0]   hi;
      logic [31:0]   lo;
      logic          err;
   } wb_t;

   logic          clk;
   logic          rst;
   logic          valid_EX, WriteReg_EX, MemOrAlu_EX, WriteMem_EX;
   logic [1:0]    mem_size_EX;
   logic          mem_signed_EX;
   logic [AW-1:0] target_EX;
   logic [31:0]   alu_out_EX, rdata_2_EX;
   logic          we_hi_EX, we_lo_EX;
   logic [31:0]   hi_EX, lo_EX;
   logic          ram_req, ram_we;
   logic [31:0]   ram_addr, ram_wdata;
   logic [3:0]    ram_sel;
   logic          ram_ack;
   logic [31:0]   ram_rdata;
   logic          stall_req;
   logic          valid_WB, WriteReg_WB, we_hi_WB, we_lo_WB;
   logic [AW-1:0] target_WB;
   logic [31:0]   wdata_WB, hi_WB, lo_WB;
   logic          addr_err_WB;
   logic          fwd_we_MEM;
   logic [AW-1:0] fwd_addr_MEM;
   logic [31:0]   fwd_data_MEM;

   mem_access_stage #(.DATA_W(32), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .valid_EX(valid_EX), .WriteReg_EX(WriteReg_EX), .MemOrAlu_EX(MemOrAlu_EX),
      .WriteMem_EX(WriteMem_EX), .mem_size_EX(mem_size_EX), .mem_signed_EX(mem_signed_EX),
      .target_EX(target_EX), .alu_out_EX(alu_out_EX), .rdata_2_EX(rdata_2_EX),
      .we_hi_EX(we_hi_EX), .we_lo_EX(we_lo_EX), .hi_EX(hi_EX), .lo_EX(lo_EX),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_sel(ram_sel), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .stall_req(stall_req),
      .valid_WB(valid_WB), .WriteReg_WB(WriteReg_WB), .we_hi_WB(we_hi_WB),
      .we_lo_WB(we_lo_WB), .target_WB(target_WB), .wdata_WB(wdata_WB),
      .hi_WB(hi_WB), .lo_WB(lo_WB), .addr_err_WB(addr_err_WB),
      .fwd_we_MEM(fwd_we_MEM), .fwd_addr_MEM(fwd_addr_MEM), .fwd_data_MEM(fwd_data_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: op held in MEM, whether it still owes a RAM access,
   // and the WB outputs expected after the last edge
   op_t m_op;
   bit  m_busy;
   bit  m_known;
   wb_t e_wb;
   int  m_wait;

   // snapshot of the DUT taken mid-cycle by cycle()
   logic        s_stall, s_req, s_we, s_fwd_we;
   logic [31:0] s_addr, s_wdata, s_fwd_data;
   logic [3:0]  s_sel;
   logic [4:0]  s_fwd_addr;
   wb_t         s_wb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic bit is_mem(input op_t o);
      return o.valid && (o.mor || o.wmem);
   endfunction

   function automatic bit mis(input op_t o);
      int a;
      a = int'(o.alu % 32'd4);
      if (o.size == 2'b00) return 1'b0;
      if (o.size == 2'b01) return (a % 2) != 0;
      return a != 0;
   endfunction

   function automatic logic [3:0] sel_of(input op_t o);
      int a;
      a = int'(o.alu % 32'd4);
      if (o.size == 2'b00) return 4'(1 << a);
      if (o.size == 2'b01) return (a >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] wdata_of(input op_t o);
      if (o.size == 2'b00) return (o.st & 32'd255) * 32'h01010101;
      if (o.size == 2'b01) return (o.st & 32'd65535) * 32'h00010001;
      return o.st;
   endfunction

   function automatic logic [31:0] load_of(input op_t o, input logic [31:0] rd);
      int     a;
      longint v;
      a = int'(o.alu % 32'd4);
      if (o.size == 2'b00) begin
         v = longint'((rd >> (8 * a)) & 32'd255);
         if (o.sgn && v >= 128) v = v - 256;
      end else if (o.size == 2'b01) begin
         v = longint'((rd >> (16 * (a / 2))) & 32'd65535);
         if (o.sgn && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(rd);
      end
      return v[31:0];
   endfunction

   function automatic wb_t wb_of(input op_t o, input logic [31:0] rd);
      wb_t w;
      bit  e;
      w = '0;
      e = is_mem(o) && mis(o);
      if (o.valid) begin
         w.valid = 1'b1;
         w.wreg  = o.wreg && !e;
         w.whi   = o.whi;
         w.wlo   = o.wlo;
         w.tgt   = o.tgt;
         w.hi    = o.hi;
         w.lo    = o.lo;
         w.err   = e;
         w.wdata = (o.mor && !e) ? load_of(o, rd) : o.alu;
      end
      return w;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int  kind;
      o       = '0;
      o.valid = ($urandom_range(0, 7) != 0);
      kind    = int'($urandom_range(0, 2));
      o.mor   = (kind == 1);
      o.wmem  = (kind == 2);
      o.wreg  = (kind != 2) && ($urandom_range(0, 3) != 0);
      o.size  = 2'($urandom_range(0, 2));
      o.sgn   = 1'($urandom);
      o.tgt   = 5'($urandom);
      o.alu   = $urandom;
      if (kind != 0 && $urandom_range(0, 1) == 1) o.alu[1:0] = 2'b00;
      o.st    = $urandom;
      o.whi   = ($urandom_range(0, 3) == 0);
      o.wlo   = ($urandom_range(0, 3) == 0);
      o.hi    = $urandom;
      o.lo    = $urandom;
      return o;
   endfunction

   // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
   task automatic cycle(input op_t op, input bit r, input bit ack, input logic [31:0] rd);
      bit stall_e;
      @(negedge clk);
      rst           = r;
      ram_ack       = ack;
      ram_rdata     = rd;
      valid_EX      = op.valid;
      WriteReg_EX   = op.wreg;
      MemOrAlu_EX   = op.mor;
      WriteMem_EX   = op.wmem;
      mem_size_EX   = op.size;
      mem_signed_EX = op.sgn;
      target_EX     = op.tgt;
      alu_out_EX    = op.alu;
      rdata_2_EX    = op.st;
      we_hi_EX      = op.whi;
      we_lo_EX      = op.wlo;
      hi_EX         = op.hi;
      lo_EX         = op.lo;
      #1;
      s_stall = stall_req;  s_req = ram_req;  s_we = ram_we;
      s_addr  = ram_addr;   s_wdata = ram_wdata; s_sel = ram_sel;
      s_fwd_we = fwd_we_MEM; s_fwd_addr = fwd_addr_MEM; s_fwd_data = fwd_data_MEM;
      s_wb = '{valid: valid_WB, wreg: WriteReg_WB, whi: we_hi_WB, wlo: we_lo_WB,
               tgt: target_WB, wdata: wdata_WB, hi: hi_WB, lo: lo_WB, err: addr_err_WB};
      stall_e = m_busy && !ack;
      if (m_known) begin
         chk1("ram_req", ram_req, m_busy);
         chk1("stall_req", stall_req, stall_e);
         chk1("ram_we", ram_we, m_busy && m_op.wmem);
         chk("ram_addr", ram_addr, m_busy ? (m_op.alu - (m_op.alu % 32'd4)) : 32'd0);
         chk("ram_sel", 32'(ram_sel), m_busy ? 32'(sel_of(m_op)) : 32'd0);
         chk("ram_wdata", ram_wdata, m_busy ? wdata_of(m_op) : 32'd0);
         chk1("valid_WB", valid_WB, e_wb.valid);
         chk1("WriteReg_WB", WriteReg_WB, e_wb.wreg);
         chk1("we_hi_WB", we_hi_WB, e_wb.whi);
         chk1("we_lo_WB", we_lo_WB, e_wb.wlo);
         chk("target_WB", 32'(target_WB), 32'(e_wb.tgt));
         chk("wdata_WB", wdata_WB, e_wb.wdata);
         chk("hi_WB", hi_WB, e_wb.hi);
         chk("lo_WB", lo_WB, e_wb.lo);
         chk1("addr_err_WB", addr_err_WB, e_wb.err);
`ifdef MEM_FWD_EN
         chk1("fwd_we_MEM", fwd_we_MEM, m_op.valid && m_op.wreg && !m_op.mor);
         chk("fwd_addr_MEM", 32'(fwd_addr_MEM), 32'(m_op.tgt));
         chk("fwd_data_MEM", fwd_data_MEM, m_op.alu);
`else
         chk1("fwd_we_MEM", fwd_we_MEM, 1'b0);
         chk("fwd_addr_MEM", 32'(fwd_addr_MEM), 32'd0);
         chk("fwd_data_MEM", fwd_data_MEM, 32'd0);
`endif
      end
      @(posedge clk);
      if (r) begin
         m_op    = '0;
         m_busy  = 1'b0;
         e_wb    = '0;
         m_known = 1'b1;
      end else begin
         e_wb = stall_e ? wb_t'('0) : wb_of(m_op, rd);
         if (!stall_e) begin
            m_op   = op;
            m_busy = is_mem(op) && !mis(op);
         end
      end
   endtask

   initial begin
      op_t         nop;
      op_t         o;
      int          nst;
      bit          ack;
      bit          prev;
      bit          r;
      logic [31:0] rd;

      nop = '0;
      m_op = '0; m_busy = 1'b0; m_known = 1'b0; e_wb = '0; m_wait = 0;
      rst = 1'b1; ram_ack = 1'b0; ram_rdata = 32'd0;
      valid_EX = 1'b0; WriteReg_EX = 1'b0; MemOrAlu_EX = 1'b0; WriteMem_EX = 1'b0;
      mem_size_EX = 2'b00; mem_signed_EX = 1'b0; target_EX = 5'd0;
      alu_out_EX = 32'd0; rdata_2_EX = 32'd0; we_hi_EX = 1'b0; we_lo_EX = 1'b0;
      hi_EX = 32'd0; lo_EX = 32'd0;

      // reset state
      cycle(nop, 1'b1, 1'b0, 32'd0);
      cycle(nop, 1'b1, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("reset valid_WB", s_wb.valid, 1'b0);
      chk1("reset ram_req", s_req, 1'b0);
      chk1("reset stall_req", s_stall, 1'b0);
      chk("reset wdata_WB", s_wb.wdata, 32'd0);

      // ALU op
      o = nop; o.valid = 1'b1; o.wreg = 1'b1; o.alu = 32'h0000_1234; o.tgt = 5'd5;
      nst = 0;
      cycle(o, 1'b0, 1'b0, 32'd0);   nst += int'(s_stall);
      cycle(nop, 1'b0, 1'b0, 32'd0); nst += int'(s_stall);
      cycle(nop, 1'b0, 1'b0, 32'd0); nst += int'(s_stall);
      chk1("alu valid_WB", s_wb.valid, 1'b1);
      chk1("alu WriteReg_WB", s_wb.wreg, 1'b1);
      chk("alu wdata_WB", s_wb.wdata, 32'h0000_1234);
      chk("alu target_WB", 32'(s_wb.tgt), 32'd5);
      chk("alu stall cycles", 32'(nst), 32'd0);

      // signed byte load, ack after three wait cycles
      o = nop; o.valid = 1'b1; o.wreg = 1'b1; o.mor = 1'b1; o.size = 2'b00;
      o.sgn = 1'b1; o.alu = 32'h0000_0103; o.tgt = 5'd9;
      cycle(o, 1'b0, 1'b0, 32'd0);
      nst = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(nop, 1'b0, 1'b0, 32'h80FF_FFFF);
         nst += int'(s_stall);
         if (i == 0) begin
            chk("lb ram_addr", s_addr, 32'h0000_0100);
            chk("lb ram_sel", 32'(s_sel), 32'h8);
         end
      end
      chk("lb stall cycles", 32'(nst), 32'd3);
      cycle(nop, 1'b0, 1'b1, 32'h80FF_FFFF);
      chk1("lb ack releases stall", s_stall, 1'b0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk("lb wdata_WB", s_wb.wdata, 32'hFFFF_FF80);
      chk1("lb WriteReg_WB", s_wb.wreg, 1'b1);

      // half store, zero-wait RAM
      o = nop; o.valid = 1'b1; o.wmem = 1'b1; o.size = 2'b01;
      o.alu = 32'h0000_0202; o.st = 32'hAAAA_BEEF;
      cycle(o, 1'b0, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b1, 32'd0);
      chk1("sh ram_we", s_we, 1'b1);
      chk("sh ram_sel", 32'(s_sel), 32'hC);
      chk("sh ram_wdata", s_wdata, 32'hBEEF_BEEF);
      chk1("sh stall_req", s_stall, 1'b0);

      // misaligned word load
      o = nop; o.valid = 1'b1; o.wreg = 1'b1; o.mor = 1'b1; o.size = 2'b10;
      o.alu = 32'h0000_0301;
      cycle(o, 1'b0, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("lw-mis ram_req", s_req, 1'b0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("lw-mis addr_err_WB", s_wb.err, 1'b1);
      chk1("lw-mis WriteReg_WB", s_wb.wreg, 1'b0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("lw-mis err one cycle", s_wb.err, 1'b0);

      // reset in the second access cycle, then a stray ack
      o = nop; o.valid = 1'b1; o.wreg = 1'b1; o.mor = 1'b1; o.size = 2'b10;
      o.alu = 32'h0000_0400;
      cycle(o, 1'b0, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("rst-mid ram_req before", s_req, 1'b1);
      cycle(nop, 1'b1, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b1, 32'hDEAD_BEEF);
      chk1("rst-mid ram_req after", s_req, 1'b0);
      chk1("rst-mid valid_WB", s_wb.valid, 1'b0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
      chk1("stray ack valid_WB", s_wb.valid, 1'b0);
      chk("stray ack wdata_WB", s_wb.wdata, 32'd0);

      // forwarding of an ALU result
      o = nop; o.valid = 1'b1; o.wreg = 1'b1; o.alu = 32'h0000_0055; o.tgt = 5'd7;
      cycle(o, 1'b0, 1'b0, 32'd0);
      cycle(nop, 1'b0, 1'b0, 32'd0);
`ifdef MEM_FWD_EN
      chk1("fwd we", s_fwd_we, 1'b1);
      chk("fwd addr", 32'(s_fwd_addr), 32'd7);
      chk("fwd data", s_fwd_data, 32'h0000_0055);
`else
      chk1("fwd we", s_fwd_we, 1'b0);
      chk("fwd addr", 32'(s_fwd_addr), 32'd0);
      chk("fwd data", s_fwd_data, 32'd0);
`endif
      cycle(nop, 1'b0, 1'b0, 32'd0);

      // randomized traffic with random RAM latency, stray acks and resets
      for (int n = 0; n < 3000; n++) begin
         if (m_busy) ack = (m_wait == 0);
         else        ack = ($urandom_range(0, 7) == 0);
         r    = ($urandom_range(0, 199) == 0);
         rd   = $urandom;
         prev = m_busy;
         cycle(rand_op(), r, ack, rd);
         if (m_busy) begin
            if (!prev || ack) m_wait = int'($urandom_range(0, 3));
            else if (m_wait > 0) m_wait--;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
